// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV64M multiply/divide sequencer:
// widths, funct3 op encodings, FSM states and a word sign-extend helper.
package muldiv_pkg;

  localparam int XLEN = 64;
  localparam int WLEN = 32;

  typedef enum logic [2:0] {
    DivMul    = 3'b000,
    DivMulh   = 3'b001,
    DivMulhsu = 3'b010,
    DivMulhu  = 3'b011,
    DivDiv    = 3'b100,
    DivDivu   = 3'b101,
    DivRem    = 3'b110,
    DivRemu   = 3'b111
  } div_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic [XLEN-1:0] sext_word(
    input logic [WLEN-1:0] v
  );
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Per-cycle mul/div datapath: shift-add multiply or restoring divide step.
// Ports: load/step controls, magnitudes opa/opb, next-state hi/lo views.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  // hi: upper product half / partial remainder
  // lo: multiplier+low product / dividend+quotient
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] sub;
  logic            ge;

  always_comb begin
    mul_sum = {1'b0, hi_q}
            + (lo_q[0] ? {1'b0, opnd_q} : '0);
    trial = {hi_q, lo_q[XLEN-1]};
    ge    = trial >= {1'b0, opnd_q};
    // when ge holds the difference is below
    // the divisor, so XLEN bits suffice
    sub   = trial[XLEN-1:0] - opnd_q;
    if (is_div) begin
      hi_nxt = ge ? sub : trial[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], ge};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= opa;
      opnd_q <= opb;
    end else if (step) begin
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage RV64M sequencer: FSM, counter, special cases, sign fix-up.
// Ports: div_en/div_sel/is_word/src1/src2 in, flush, handshake, stall.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            div_en_i,
  input  logic [2:0]      div_sel_i,
  input  logic            is_word_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            in_ready_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            stall_o
);

  localparam logic [6:0] LAST_D = 7'(XLEN-1);
  localparam logic [6:0] LAST_W = 7'(WLEN-1);

  md_state_e state_q, state_d;
  logic [6:0] cnt_q;
  div_sel_e   op_q;
  logic       word_q;
  logic       neg_q;
  logic [XLEN-1:0] result_q;

  logic accept;
  logic load;
  logic step;
  logic last;

  div_sel_e        op_in;
  logic            s1, s2;
  logic            is_div_in;
  logic [XLEN-1:0] a_ext, b_ext;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] load_a;
  logic [XLEN-1:0] min_val;
  logic            div_zero, div_ovf;
  logic            special;
  logic [XLEN-1:0] spec_raw, spec_res;
  logic            neg_in;

  logic [XLEN-1:0]   hi_nxt, lo_nxt;
  logic [2*XLEN-1:0] prod, prod_al, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;
  logic [XLEN-1:0]   fin, fin_res;

  assign accept = div_en_i & (state_q == MD_IDLE)
                & ~flush_i;
  assign last = cnt_q == (word_q ? LAST_W : LAST_D);
  assign result_o = result_q;

  // operand conditioning at the effective width
  always_comb begin
    op_in = div_sel_e'(div_sel_i);
    s1 = op_in inside {DivMulh, DivMulhsu,
                       DivDiv, DivRem};
    s2 = op_in inside {DivMulh, DivDiv, DivRem};
    is_div_in = div_sel_i[2];
    a_ext = src1_i;
    b_ext = src2_i;
    if (is_word_i) begin
      a_ext = s1 ? sext_word(src1_i[WLEN-1:0])
                 : {{(XLEN-WLEN){1'b0}},
                    src1_i[WLEN-1:0]};
      b_ext = s2 ? sext_word(src2_i[WLEN-1:0])
                 : {{(XLEN-WLEN){1'b0}},
                    src2_i[WLEN-1:0]};
    end
    a_neg = s1 & a_ext[XLEN-1];
    b_neg = s2 & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    // word divides start with the dividend in
    // the top half so 32 shifts consume it
    load_a = (is_div_in & is_word_i)
           ? (a_mag << WLEN) : a_mag;
    min_val = is_word_i
      ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
      : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div_in & (b_ext == '0);
    div_ovf  = is_div_in & s1 & (a_ext == min_val)
             & (b_ext == '1);
    special  = div_zero | div_ovf;
    if (div_zero)
      spec_raw = div_sel_i[1] ? a_ext : '1;
    else
      spec_raw = div_sel_i[1] ? '0 : a_ext;
    spec_res = is_word_i
             ? sext_word(spec_raw[WLEN-1:0])
             : spec_raw;
    // remainder follows the dividend sign only
    neg_in = (is_div_in & div_sel_i[1])
           ? a_neg : (a_neg ^ b_neg);
  end

  // final fix-up from the last step's values
  always_comb begin
    prod = {hi_nxt, lo_nxt};
    prod_al = word_q ? (prod >> WLEN) : prod;
    prod_fix = neg_q ? -prod_al : prod_al;
    quot_fix = neg_q ? -lo_nxt : lo_nxt;
    rem_fix  = neg_q ? -hi_nxt : hi_nxt;
    fin = prod_fix[XLEN-1:0];
    unique case (op_q)
      DivMul:    fin = prod_fix[XLEN-1:0];
      DivMulh,
      DivMulhsu,
      DivMulhu:  fin = prod_fix[2*XLEN-1:XLEN];
      DivDiv,
      DivDivu:   fin = quot_fix;
      DivRem,
      DivRemu:   fin = rem_fix;
    endcase
    fin_res = word_q ? sext_word(fin[WLEN-1:0])
                     : fin;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    stall_o     = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        in_ready_o = 1'b1;
        stall_o    = div_en_i;
        if (accept) begin
          load    = ~special;
          state_d = special ? MD_DONE : MD_CALC;
        end
      end
      MD_CALC: begin
        stall_o = 1'b1;
        step    = 1'b1;
        if (last)
          state_d = MD_DONE;
      end
      MD_DONE: begin
        out_valid_o = 1'b1;
        stall_o     = ~out_ready_i;
        if (out_ready_i)
          state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush_i)
      state_d = MD_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= MD_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= DivMul;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      op_q   <= op_in;
      word_q <= is_word_i;
      neg_q  <= neg_in;
      if (special)
        result_q <= spec_res;
    end else if (state_q == MD_CALC) begin
      cnt_q <= cnt_q + 7'd1;
      if (last)
        result_q <= fin_res;
    end
  end

  muldiv_iter u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (op_q[2]),
    .opa    (load_a),
    .opb    (b_mag),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table with a scoreboard
// queue plus hand sequences for flush, back-pressure and reset.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            div_en;
  logic [2:0]      div_sel;
  logic            is_word;
  logic [XLEN-1:0] src1, src2;
  logic            flush;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            stall;

  int passed = 0;
  int total  = 0;
  int hs_cnt = 0;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic         word;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [63:0]  res;
    int           lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] res;
    int          lat;
  } exp_t;

  vec_t vecs[23];
  exp_t sb[$];

  muldiv_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .div_en_i    (div_en),
    .div_sel_i   (div_sel),
    .is_word_i   (is_word),
    .src1_i      (src1),
    .src2_i      (src2),
    .flush_i     (flush),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .stall_o     (stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (out_valid && out_ready)
      hs_cnt++;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got === exp)
      passed++;
    else
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
  endtask

  // lat = clock edges after the accept edge
  // until out_valid is seen
  task automatic run_vec(input vec_t v);
    exp_t e;
    int n;
    int low_stall;
    div_sel = v.op;
    is_word = v.word;
    src1    = v.a;
    src2    = v.b;
    div_en  = 1'b1;
    #1;
    chk({v.name, " stall@T"}, 64'(stall), 64'd1);
    sb.push_back('{v.name, v.res, v.lat});
    @(posedge clk); #1;
    div_en = 1'b0;
    n = 0;
    low_stall = 0;
    while (!out_valid && n < 100) begin
      if (!stall) low_stall++;
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk({e.name, " valid"}, 64'(out_valid), 64'd1);
    chk({e.name, " lat"}, 64'(n), 64'(e.lat));
    chk({e.name, " res"}, result, e.res);
    chk({e.name, " calc stall"},
        64'(low_stall), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] held;
    int hs0;
    int seen;

    vecs[0]  = '{"mul", 3'b000, 1'b0, 64'd7,
                 -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 64};
    vecs[1]  = '{"mulhu", 3'b011, 1'b0, '1, '1,
                 64'hFFFF_FFFF_FFFF_FFFE, 64};
    vecs[2]  = '{"mulh", 3'b001, 1'b0, '1, '1,
                 64'd0, 64};
    vecs[3]  = '{"mulhsu", 3'b010, 1'b0, '1, 64'd2,
                 '1, 64};
    vecs[4]  = '{"div", 3'b100, 1'b0, -64'sd20,
                 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 64};
    vecs[5]  = '{"rem", 3'b110, 1'b0, -64'sd20,
                 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64};
    vecs[6]  = '{"remu", 3'b111, 1'b0, 64'd20,
                 64'd6, 64'd2, 64};
    vecs[7]  = '{"divu0", 3'b101, 1'b0, 64'd5,
                 64'd0, '1, 0};
    vecs[8]  = '{"rem_ovf", 3'b110, 1'b0,
                 64'h8000_0000_0000_0000, '1, 64'd0, 0};
    vecs[9]  = '{"div_ovf", 3'b100, 1'b0,
                 64'h8000_0000_0000_0000, '1,
                 64'h8000_0000_0000_0000, 0};
    vecs[10] = '{"divuw", 3'b101, 1'b1,
                 64'hFFFF_FFFF, 64'd1, '1, 32};
    vecs[11] = '{"mulw", 3'b000, 1'b1,
                 64'h4000_0000, 64'd2,
                 64'hFFFF_FFFF_8000_0000, 32};
    vecs[12] = '{"divw", 3'b100, 1'b1,
                 64'h1234_5678_FFFF_FFF9, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFD, 32};
    vecs[13] = '{"remw", 3'b110, 1'b1,
                 64'h1234_5678_FFFF_FFF9, 64'd2,
                 '1, 32};
    vecs[14] = '{"divw0", 3'b100, 1'b1, 64'd5,
                 64'h1_0000_0000, '1, 0};
    vecs[15] = '{"remw_ovf", 3'b110, 1'b1,
                 64'hAAAA_0000_8000_0000,
                 64'hFFFF_FFFF, 64'd0, 0};
    vecs[16] = '{"divw_ovf", 3'b100, 1'b1,
                 64'hAAAA_0000_8000_0000,
                 64'hFFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000, 0};
    vecs[17] = '{"remuw", 3'b111, 1'b1,
                 64'h1_0000_0007, 64'h1_0000_0002,
                 64'd1, 32};
    vecs[18] = '{"mulhu_2^64", 3'b011, 1'b0,
                 64'h1_0000_0000, 64'h1_0000_0000,
                 64'd1, 64};
    vecs[19] = '{"divu", 3'b101, 1'b0, '1, 64'd3,
                 64'h5555_5555_5555_5555, 64};
    vecs[20] = '{"remuw_f", 3'b111, 1'b1,
                 64'hFFFF_FFFF, 64'h10, 64'hF, 32};
    vecs[21] = '{"divuw_msb", 3'b101, 1'b1,
                 64'h8000_0000, 64'd1,
                 64'hFFFF_FFFF_8000_0000, 32};
    vecs[22] = '{"div_min2", 3'b100, 1'b0,
                 64'h8000_0000_0000_0000, 64'd2,
                 64'hC000_0000_0000_0000, 64};

    rst = 1'b1;
    div_en = 1'b0;
    div_sel = 3'b000;
    is_word = 1'b0;
    src1 = '0;
    src2 = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst valid", 64'(out_valid), 64'd0);
    chk("rst result", result, 64'd0);
    chk("rst ready", 64'(in_ready), 64'd1);
    chk("rst stall", 64'(stall), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 23; i++)
      run_vec(vecs[i]);

    // flush during CALC: result dropped
    div_sel = 3'b100;
    is_word = 1'b0;
    src1 = -64'sd20;
    src2 = 64'd6;
    div_en = 1'b1;
    @(posedge clk); #1;
    div_en = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush ready", 64'(in_ready), 64'd1);
    chk("flush valid", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush no result", 64'(seen), 64'd0);

    // flush coincident with a request: no accept
    div_sel = 3'b101;
    src1 = 64'd5;
    src2 = 64'd0;
    div_en = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    div_en = 1'b0;
    flush = 1'b0;
    chk("flush+en valid", 64'(out_valid), 64'd0);
    chk("flush+en ready", 64'(in_ready), 64'd1);

    // back-pressure in DONE, then no back-to-back
    hs0 = hs_cnt;
    out_ready = 1'b0;
    div_sel = 3'b100;
    src1 = -64'sd20;
    src2 = 64'd6;
    div_en = 1'b1;
    @(posedge clk); #1;
    div_en = 1'b0;
    seen = 0;
    while (!out_valid && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("bp valid", 64'(out_valid), 64'd1);
    chk("bp res", result, 64'hFFFF_FFFF_FFFF_FFFD);
    held = result;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp hold valid", 64'(out_valid), 64'd1);
      chk("bp hold stall", 64'(stall), 64'd1);
      chk("bp hold res", result, held);
    end
    out_ready = 1'b1;
    div_sel = 3'b101;
    src1 = 64'd5;
    src2 = 64'd0;
    div_en = 1'b1;
    #1;
    chk("bp release stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    chk("no b2b valid", 64'(out_valid), 64'd0);
    chk("no b2b ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    div_en = 1'b0;
    chk("next valid", 64'(out_valid), 64'd1);
    chk("next res", result, '1);
    @(posedge clk); #1;
    chk("handshakes", 64'(hs_cnt - hs0), 64'd2);

    // reset mid-operation
    div_sel = 3'b000;
    src1 = 64'd7;
    src2 = -64'sd3;
    div_en = 1'b1;
    @(posedge clk); #1;
    div_en = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid rst valid", 64'(out_valid), 64'd0);
    chk("mid rst ready", 64'(in_ready), 64'd1);
    chk("mid rst result", result, 64'd0);
    chk("mid rst stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid rst no result", 64'(seen), 64'd0);
    run_vec(vecs[5]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Execute-stage sequencer for the RV64M multiply/divide unit; consumes the decode-stage DivEn/DivSel controls and the word-variant flag.
- Runs iterative shift-add multiplication and restoring division, handles the special cases, and stalls the pipeline until the result is accepted.
- Sits beside the ALU in EX; its result is muxed into the EX result when a mul/div instruction completes.

Parameters:
- XLEN, 64, operand/result width.
- WLEN, 32, word-variant operand width (*W instructions).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- div_en_i  in  1  start request (decoder DivEn, qualified by EX valid)
- div_sel_i  in  3  op = funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- is_word_i  in  1  OP_REG_32 variant (mulw/divw/divuw/remw/remuw)
- src1_i  in  XLEN  rs1 operand
- src2_i  in  XLEN  rs2 operand
- flush_i  in  1  pipeline flush/trap redirect; kills any operation
- in_ready_o  out  1  high only in IDLE
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream (EX/MEM register) accepts result
- result_o  out  XLEN  final result
- stall_o  out  1  hold IF/ID/EX

Behaviour:
- Reset: state=IDLE, out_valid_o=0, result_o=0, counter=0, all internal regs 0; in_ready_o=1, stall_o=0.
- Accept: div_en_i & in_ready_o & ~flush_i at edge T latches op, word flag and operands.
- FSM states:
  - IDLE -> CALC on a normal accept.
  - IDLE -> DONE on a special-case accept.
  - CALC -> DONE when counter reaches N-1.
  - DONE -> IDLE when out_ready_i is high.
  - Any state -> IDLE when flush_i is high (highest priority).
- N = XLEN for 64-bit ops, WLEN when is_word_i is set; counter increments once per CALC cycle.
- Latency: normal op gives out_valid_o from cycle T+N+1 (64-bit: 65 cycles, word: 33). Special case gives out_valid_o from T+1.
- out_valid_o is high exactly in DONE; result_o is stable throughout DONE; back-pressure holds DONE indefinitely.
- stall_o = (IDLE & div_en_i) | CALC | (DONE & ~out_ready_i).
- Word ops:
  - Operands are the low 32 bits, sign- or zero-extended per signedness.
  - Result is bits[31:0] of the 32-bit result, sign-extended to XLEN. This includes divuw/remuw and mulw.
  - div_sel_i 001–011 with is_word_i set is illegal; output is don't-care but the FSM must still complete and return to IDLE.
- Signedness:
  - mul: low XLEN bits of the product; sign handling is irrelevant.
  - mulh and div/rem: both operands signed.
  - mulhsu: src1 signed, src2 unsigned.
  - mulhu and divu/remu: unsigned.
  - The datapath works on magnitudes and applies the final 2's-complement negate in the DONE-entry cycle.
  - Quotient sign = sign1 XOR sign2; remainder sign = dividend sign.
- Multiply: 2·XLEN-bit accumulator, one partial product per cycle. mulh/mulhsu/mulhu return the upper XLEN bits; mul returns the lower XLEN bits.
- Divide: restoring, one quotient bit per cycle; partial remainder is XLEN+1 bits.
- Special cases (decided at accept, no iteration, evaluated at effective width):
  - Divisor 0: quotient = all ones (-1), remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend, remainder = 0.
- Flush:
  - Flush in CALC/DONE drops the result; out_valid_o is low the next cycle.
  - Flush coincident with div_en_i in IDLE: no accept.
  - Flush has priority over out_ready_i.
- Simultaneous DONE & out_ready_i & div_en_i: no back-to-back accept. Returns to IDLE first; the new op is accepted at the earliest the following cycle.
- Reset asserted mid-operation: immediate return to reset values; no result is produced.

Decomposition:
- Shared defines header (the existing global defines file):
  - DivSel encodings (DivMul, DivMulh, DivMulhsu, DivMulhu, DivDiv, DivDivu, DivRem, DivRemu).
  - FSM state encodings MD_IDLE/MD_CALC/MD_DONE.
  - XLEN / WLEN.
- One sub-module, muldiv_iter:
  - Pure per-cycle datapath step (accumulator/partial-remainder registers, shift-add and trial-subtract), driven by load/step controls.
  - muldiv_ctrl owns the FSM, counter, special-case detection, sign fix-up and handshake.

Test Plan:
- mul src1=7, src2=-3 (64-bit), out_ready_i=1 -> out_valid_o at T+65, result_o=0xFFFF_FFFF_FFFF_FFEB, stall_o high T..T+64.
- mulhu src1=src2=0xFFFF_FFFF_FFFF_FFFF -> result_o=0xFFFF_FFFF_FFFF_FFFE; mulh same operands -> 0.
- div src1=-20, src2=6 -> -3 (0xFFFF_FFFF_FFFF_FFFD); rem same operands -> -2; remu 20,6 -> 2.
- divu src2=0, src1=5 -> result_o=all ones at T+1; rem src1=0x8000_0000_0000_0000, src2=-1 -> 0 at T+1; div same operands -> 0x8000_0000_0000_0000.
- divuw src1=0xFFFF_FFFF, src2=1, is_word_i=1 -> out_valid_o at T+33, result_o=0xFFFF_FFFF_FFFF_FFFF (sign-extended); mulw 0x4000_0000*2 -> 0xFFFF_FFFF_8000_0000.
- Start div, flush_i at T+10 -> IDLE at T+11, no out_valid_o ever; then hold out_ready_i=0 in DONE for 5 cycles -> result_o stable, stall_o high, single completion after release.
